// File: rtl/pe_pkg.sv
// Shared widths and limits for the SAD processing element.
package pe_pkg;
    localparam int unsigned       PIXEL_W = 8;
    localparam logic [PIXEL_W-1:0] SAD_MAX = 8'hFF;
endpackage

// File: rtl/processing_element_abs_diff.sv
// Combinational unsigned absolute difference |a - b|.
module abs_diff
    import pe_pkg::*;
(
    input  logic [PIXEL_W-1:0] a,
    input  logic [PIXEL_W-1:0] b,
    output logic [PIXEL_W-1:0] d
);
    always_comb begin
        d = (a >= b) ? (a - b) : (b - a);
    end
endmodule

// File: rtl/processing_element.sv
// One SAD processing element: selects a search pixel, accumulates |r - s| with
// saturation, and forwards r one cycle later to the next element.
module processing_element
    import pe_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [PIXEL_W-1:0] r,
    input  logic [PIXEL_W-1:0] s1,
    input  logic [PIXEL_W-1:0] s2,
    input  logic               s1s2_mux,
    input  logic               new_dist,
    output logic [PIXEL_W-1:0] accumulate,
    output logic [PIXEL_W-1:0] r_pipe
);
    logic [PIXEL_W-1:0] w_s_sel;
    logic [PIXEL_W-1:0] w_diff;
    logic [PIXEL_W:0]   w_sum;
    logic [PIXEL_W-1:0] w_sat;
    logic [PIXEL_W-1:0] r_acc;
    logic [PIXEL_W-1:0] r_pipe_q;

    always_comb begin
        w_s_sel = s1s2_mux ? s2 : s1;
    end

    abs_diff u_abs_diff (
        .a (r),
        .b (w_s_sel),
        .d (w_diff)
    );

    // Extra carry bit detects overflow so the sum clamps instead of wrapping.
    always_comb begin
        w_sum = {1'b0, r_acc} + {1'b0, w_diff};
        w_sat = w_sum[PIXEL_W] ? SAD_MAX : w_sum[PIXEL_W-1:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_pipe_q <= '0;
        end else begin
            r_acc    <= new_dist ? w_diff : w_sat;
            r_pipe_q <= r;
        end
    end

    assign accumulate = r_acc;
    assign r_pipe     = r_pipe_q;
endmodule

// File: tb/tb_processing_element.sv
// Scoreboard bench for processing_element: driver pushes expected SAD/pipe values,
// a monitor pops and compares one entry after every rising edge.
module tb_processing_element;
    logic       clock;
    logic       reset_n;
    logic [7:0] r, s1, s2;
    logic       s1s2_mux, new_dist;
    logic [7:0] accumulate, r_pipe;

    typedef struct {
        logic [7:0] acc;
        logic [7:0] pipe;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_sum  = 0;
    int   n_step = 0;

    processing_element dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .r          (r),
        .s1         (s1),
        .s2         (s2),
        .s1s2_mux   (s1s2_mux),
        .new_dist   (new_dist),
        .accumulate (accumulate),
        .r_pipe     (r_pipe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one edge worth of inputs and record what the outputs must be after it.
    task automatic step(input logic [7:0] rr, input logic [7:0] s1v, input logic [7:0] s2v,
                        input logic mux, input logic nd);
        int   sv, rv, d;
        exp_t e;
        @(negedge clock);
        r = rr; s1 = s1v; s2 = s2v; s1s2_mux = mux; new_dist = nd;
        rv = int'(rr);
        sv = mux ? int'(s2v) : int'(s1v);
        d  = (rv > sv) ? rv - sv : sv - rv;
        if (nd) m_sum = d;
        else    m_sum = (m_sum + d > 255) ? 255 : m_sum + d;
        e.acc  = 8'(m_sum);
        e.pipe = rr;
        e.tag  = n_step;
        n_step++;
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (accumulate !== 8'h00) begin
            errors++;
            $display("FAIL %s accumulate got %0d expected 0", name, accumulate);
        end
        checks++;
        if (r_pipe !== 8'h00) begin
            errors++;
            $display("FAIL %s r_pipe got %0d expected 0", name, r_pipe);
        end
    endtask

    // Monitor: one output per edge while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (accumulate !== e.acc) begin
                    errors++;
                    $display("FAIL acc step %0d got %0d expected %0d", e.tag, accumulate, e.acc);
                end
                checks++;
                if (r_pipe !== e.pipe) begin
                    errors++;
                    $display("FAIL pipe step %0d got %0d expected %0d", e.tag, r_pipe, e.pipe);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        reset_n = 1'b1;
        r = 8'd33; s1 = 8'd17; s2 = 8'd99; s1s2_mux = 1'b1; new_dist = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_zero("reset_async");
        repeat (2) @(posedge clock);
        #1 check_zero("reset_held");

        // Release reset at a falling edge so the next rising edge is a normal update.
        @(negedge clock);
        reset_n = 1'b1;
        m_sum   = 0;

        step(8'd8, 8'd0, 8'd8, 1'b1, 1'b1);     // -> 0
        step(8'd0, 8'd0, 8'd7, 1'b1, 1'b0);     // -> 7
        step(8'd1, 8'd1, 8'd5, 1'b0, 1'b0);     // +0 -> 7
        step(8'd2, 8'd1, 8'd7, 1'b1, 1'b0);     // +5 -> 12
        step(8'd5, 8'd255, 8'd0, 1'b0, 1'b1);   // -> 250
        step(8'd0, 8'd10, 8'd0, 1'b0, 1'b0);    // -> 255
        step(8'd0, 8'd10, 8'd0, 1'b0, 1'b0);    // hold 255
        step(8'd200, 8'd0, 8'd0, 1'b0, 1'b0);   // hold 255
        step(8'd2, 8'd0, 8'd0, 1'b0, 1'b1);     // -> 2
        step(8'd1, 8'd0, 8'd0, 1'b0, 1'b0);
        step(8'd2, 8'd0, 8'd0, 1'b0, 1'b0);
        step(8'd3, 8'd0, 8'd0, 1'b0, 1'b0);

        // Mid-accumulation reset pulse between edges.
        step(8'd50, 8'd20, 8'd0, 1'b0, 1'b0);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1 check_zero("reset_mid");
        #1 reset_n = 1'b1;
        m_sum = 0;
        r = 8'd10; s1 = 8'd6; s2 = 8'd0; s1s2_mux = 1'b0; new_dist = 1'b0;
        begin
            exp_t e;
            e.acc = 8'd4; e.pipe = 8'd10; e.tag = n_step;
            n_step++;
            m_sum = 4;
            exp_q.push_back(e);
        end

        for (int i = 0; i < 300; i++) begin
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clock);
            wait_cnt++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/processing_element.md
PROCESSING_ELEMENT -- requirements
Module: processing_element

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clock and reset_n as in the rest of the codebase.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 r  input  8  reference-block pixel, unsigned.
REQ-005 s1  input  8  search-window pixel, stream 1, unsigned.
REQ-006 s2  input  8  search-window pixel, stream 2, unsigned.
REQ-007 s1s2_mux  input  1  search-pixel select: 0 = s1, 1 = s2.
REQ-008 new_dist  input  1  start a new distortion sum this cycle.
REQ-009 accumulate  output  8  registered running sum of absolute differences (SAD), to the comparator.
REQ-010 r_pipe  output  8  r delayed one clock, to the next processing element.

Function
REQ-011 Selected search pixel s_sel SHALL be s2 when s1s2_mux=1, else s1 (combinational).
REQ-012 Absolute difference SHALL be |r - s_sel|, computed unsigned on 8 bits: (r >= s_sel) ? r - s_sel : s_sel - r; range 0..255.
REQ-013 On each rising clock with new_dist=1, accumulate SHALL load |r - s_sel| and discard the prior sum.
REQ-014 On each rising clock with new_dist=0, accumulate SHALL load accumulate + |r - s_sel|.
REQ-015 The addition SHALL saturate at 255: if the 9-bit sum exceeds 255, accumulate = 8'hFF; the sum never wraps.
REQ-016 Once saturated, accumulate SHALL stay at 255 until new_dist=1 or reset.
REQ-017 Latency: the difference of the inputs sampled at edge N SHALL be visible on accumulate immediately after edge N (one register stage, no additional pipeline).
REQ-018 r_pipe SHALL be loaded with r on every rising clock, independent of new_dist and s1s2_mux.
REQ-019 r_pipe therefore SHALL equal r delayed exactly one cycle.
REQ-020 Inputs SHALL be sampled only at the rising edge; changes between edges have no effect on state.
REQ-021 No enable input exists; the block SHALL update every cycle when out of reset.

Reset
REQ-022 While reset_n=0, accumulate and r_pipe SHALL be 8'h00 immediately, independent of clock.
REQ-023 Reset asserted mid-accumulation SHALL discard the partial sum.
REQ-024 After reset_n deasserts, the first rising edge SHALL update both registers normally; if new_dist=0 on that edge, the sum adds to 0.

Structure
REQ-025 Shared package pe_pkg SHALL hold localparam PIXEL_W = 8 and SAD_MAX = 8'hFF; all port widths SHALL derive from PIXEL_W.
REQ-026 A combinational sub-module abs_diff (inputs a, b [PIXEL_W-1:0]; output d [PIXEL_W-1:0]) SHALL implement REQ-012.
REQ-027 processing_element SHALL contain the mux, one abs_diff instance, the saturating adder, and the two registers.

Verification
REQ-028 Reset: drive reset_n=0 with nonzero inputs -> accumulate=0 and r_pipe=0 asynchronously, with no clock edge required.
REQ-029 New sum: r=8, s2=8, mux=1, new_dist=1 -> accumulate=0 after the edge; next edge with r=0, s2=7, new_dist=0 -> accumulate=7.
REQ-030 Mux and abs: starting from sum 7, r=1, s1=1, s2=5, mux=0 -> +0, sum stays 7; then r=2, s2=7, mux=1 -> +5, sum becomes 12.
REQ-031 Saturation: new_dist=1 with r=5, s1=255, mux=0 -> 250; next edge new_dist=0 with r=0, s1=10 -> 255; further edges hold 255; a subsequent new_dist=1 with r=2, s1=0 -> 2.
REQ-032 Pipe: apply r sequence 1, 2, 3 on consecutive edges -> r_pipe shows 1, 2, 3, each one cycle later.
REQ-033 Mid-operation reset: pulse reset_n low between edges during accumulation -> outputs clear at once; the next edge with new_dist=0 and |r - s|=4 -> accumulate=4.
